// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a one-entry skid buffer, redirect/interrupt flush
// and capture of the oldest discarded PC for mepc.
module if_id_skid_stage #(
  parameter int              XLEN         = 32,
  parameter int              SIDE_W       = 8,
  parameter logic [XLEN-1:0] BUBBLE_INSTR = 'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   pc_plus4_i,
  input  logic [SIDE_W-1:0] side_i,
  // decode side
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   instr_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   pc_plus4_o,
  output logic [SIDE_W-1:0] side_o,
  // flush control
  input  logic              flush_i,
  input  logic              int_flush_i,
  output logic [XLEN-1:0]   int_pc_o,
  output logic              int_pc_valid_o
);

  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
    logic [SIDE_W-1:0] side;
  } fetch_t;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

  state_t state;
  fetch_t main_q, skid_q, in_pkt;
  logic   main_vld, accept, deliver;

  assign in_pkt   = '{instr: instr_i, pc: pc_i, pc4: pc_plus4_i, side: side_i};

  // ready depends only on registered state and reset, never on ready_i
  assign ready_o  = (state != S_SKID) && !rst;
  assign main_vld = (state != S_EMPTY) && !rst;
  assign accept   = valid_i && ready_o;
  assign deliver  = main_vld && ready_i;

  assign valid_o    = main_vld;
  assign instr_o    = main_vld ? main_q.instr : BUBBLE_INSTR;
  assign pc_o       = main_vld ? main_q.pc    : '0;
  assign pc_plus4_o = main_vld ? main_q.pc4   : '0;
  assign side_o     = main_vld ? main_q.side  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_EMPTY;
      main_q         <= '0;
      skid_q         <= '0;
      int_pc_o       <= '0;
      int_pc_valid_o <= 1'b0;
    end else begin
      int_pc_valid_o <= 1'b0;
      if (flush_i || int_flush_i) begin
        state  <= S_EMPTY;
        main_q <= '0;
        skid_q <= '0;
        // a redirect flush means the interrupted stream is wrong-path: report nothing
        if (int_flush_i && !flush_i) begin
          if (state != S_EMPTY) begin
            int_pc_o       <= main_q.pc;
            int_pc_valid_o <= 1'b1;
          end else if (valid_i) begin
            int_pc_o       <= pc_i;
            int_pc_valid_o <= 1'b1;
          end
        end
      end else begin
        case (state)
          S_EMPTY: begin
            if (accept) begin
              main_q <= in_pkt;
              state  <= S_FULL;
            end
          end
          S_FULL: begin
            if (accept && deliver) begin
              main_q <= in_pkt;
            end else if (accept) begin
              skid_q <= in_pkt;
              state  <= S_SKID;
            end else if (deliver) begin
              main_q <= '0;
              state  <= S_EMPTY;
            end
          end
          S_SKID: begin
            if (deliver) begin
              main_q <= skid_q;
              skid_q <= '0;
              state  <= S_FULL;
            end
          end
          default: state <= S_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed vector table plus a scoreboarded backpressure stream for if_id_skid_stage.
module tb_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, valid_o, ready_i;
  logic [31:0] instr_i, pc_i, pc_plus4_i;
  logic [31:0] instr_o, pc_o, pc_plus4_o;
  logic [7:0]  side_i, side_o;
  logic        flush_i, int_flush_i, int_pc_valid_o;
  logic [31:0] int_pc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_skid_stage dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .pc_plus4_i(pc_plus4_i), .side_i(side_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .side_o(side_o),
    .flush_i(flush_i), .int_flush_i(int_flush_i),
    .int_pc_o(int_pc_o), .int_pc_valid_o(int_pc_valid_o)
  );

  // payload fields are derived from the PC so every field is traceable
  function automatic logic [31:0] f_instr(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction
  function automatic logic [7:0] f_side(input logic [31:0] pc);
    return pc[9:2] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic rd, input logic fl,
                       input logic ifl, input logic [31:0] pc);
    rst = r; valid_i = v; ready_i = rd; flush_i = fl; int_flush_i = ifl;
    pc_i = pc; instr_i = f_instr(pc); pc_plus4_i = pc + 32'd4; side_i = f_side(pc);
  endtask

  typedef struct {
    logic        rst, v, rd, fl, ifl;
    logic [31:0] pc;
    logic        e_v;
    logic [31:0] e_pc;
    logic        e_rdy, e_ipv;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic rd, input logic fl,
                     input logic ifl, input logic [31:0] pc, input logic e_v,
                     input logic [31:0] e_pc, input logic e_rdy, input logic e_ipv,
                     input logic [31:0] e_ipc);
    vec_t t;
    t = '{rst: r, v: v, rd: rd, fl: fl, ifl: ifl, pc: pc, e_v: e_v, e_pc: e_pc,
          e_rdy: e_rdy, e_ipv: e_ipv, e_ipc: e_ipc};
    vecs.push_back(t);
  endtask

  initial begin
    vec_t t;
    logic [31:0] q[$];
    logic [31:0] next_pc;
    int pushed, popped;
    logic v, rd, acc, del;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    //    rst v  rd fl ifl pc          | e_v e_pc        rdy ipv ipc
    add(1, 0, 0, 0, 0, 32'h000,    0, 32'h000,    0, 0, 32'h000); // reset state
    add(0, 0, 0, 0, 0, 32'h000,    0, 32'h000,    1, 0, 32'h000);
    add(0, 1, 1, 0, 0, 32'h100,    1, 32'h100,    1, 0, 32'h000); // stream
    add(0, 1, 1, 0, 0, 32'h104,    1, 32'h104,    1, 0, 32'h000);
    add(0, 1, 1, 0, 0, 32'h108,    1, 32'h108,    1, 0, 32'h000);
    add(0, 0, 1, 0, 0, 32'h000,    0, 32'h000,    1, 0, 32'h000);
    add(0, 1, 0, 0, 0, 32'h200,    1, 32'h200,    1, 0, 32'h000); // backpressure
    add(0, 1, 0, 0, 0, 32'h204,    1, 32'h200,    0, 0, 32'h000);
    add(0, 1, 0, 0, 0, 32'h208,    1, 32'h200,    0, 0, 32'h000); // not accepted
    add(0, 0, 1, 0, 0, 32'h000,    1, 32'h204,    1, 0, 32'h000);
    add(0, 0, 1, 0, 0, 32'h000,    0, 32'h000,    1, 0, 32'h000);
    add(0, 1, 0, 0, 0, 32'h300,    1, 32'h300,    1, 0, 32'h000); // flush in SKID
    add(0, 1, 0, 0, 0, 32'h304,    1, 32'h300,    0, 0, 32'h000);
    add(0, 1, 1, 1, 0, 32'h308,    0, 32'h000,    1, 0, 32'h000);
    add(0, 0, 1, 0, 0, 32'h000,    0, 32'h000,    1, 0, 32'h000);
    add(0, 1, 0, 0, 0, 32'h400,    1, 32'h400,    1, 0, 32'h000); // interrupt
    add(0, 0, 0, 0, 1, 32'h000,    0, 32'h000,    1, 1, 32'h400);
    add(0, 0, 0, 0, 0, 32'h000,    0, 32'h000,    1, 0, 32'h400);
    add(0, 1, 1, 0, 1, 32'h500,    0, 32'h000,    1, 1, 32'h500);
    add(0, 0, 0, 0, 0, 32'h000,    0, 32'h000,    1, 0, 32'h500);
    add(0, 1, 0, 0, 0, 32'h600,    1, 32'h600,    1, 0, 32'h500); // both flushes
    add(0, 0, 0, 1, 1, 32'h000,    0, 32'h000,    1, 0, 32'h500);
    add(0, 1, 0, 0, 0, 32'h6A0,    1, 32'h6A0,    1, 0, 32'h500); // reset in SKID
    add(0, 1, 0, 0, 0, 32'h6A4,    1, 32'h6A0,    0, 0, 32'h500);
    add(1, 1, 1, 1, 1, 32'h6A8,    0, 32'h000,    0, 0, 32'h000);
    add(0, 1, 1, 0, 0, 32'h700,    1, 32'h700,    1, 0, 32'h000);
    add(0, 0, 1, 0, 0, 32'h000,    0, 32'h000,    1, 0, 32'h000);

    foreach (vecs[i]) begin
      t = vecs[i];
      @(negedge clk);
      drive(t.rst, t.v, t.rd, t.fl, t.ifl, t.pc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid_o", i),        {31'd0, valid_o},        {31'd0, t.e_v});
      chk($sformatf("v%0d pc_o", i),           pc_o,                    t.e_pc);
      chk($sformatf("v%0d instr_o", i),        instr_o,                 t.e_v ? f_instr(t.e_pc) : 32'h0000_0013);
      chk($sformatf("v%0d pc_plus4_o", i),     pc_plus4_o,              t.e_v ? t.e_pc + 32'd4 : 32'd0);
      chk($sformatf("v%0d side_o", i),         {24'd0, side_o},         t.e_v ? {24'd0, f_side(t.e_pc)} : 32'd0);
      chk($sformatf("v%0d ready_o", i),        {31'd0, ready_o},        {31'd0, t.e_rdy});
      chk($sformatf("v%0d int_pc_valid_o", i), {31'd0, int_pc_valid_o}, {31'd0, t.e_ipv});
      chk($sformatf("v%0d int_pc_o", i),       int_pc_o,                t.e_ipc);
    end

    // Mixed valid/ready stream against a two-entry FIFO model: order, occupancy, no loss
    next_pc = 32'h1000;
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      chk($sformatf("s%0d ready_o", c), {31'd0, ready_o}, {31'd0, q.size() < 2});
      chk($sformatf("s%0d valid_o", c), {31'd0, valid_o}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
        chk($sformatf("s%0d pc_o", c),    pc_o,    q[0]);
        chk($sformatf("s%0d instr_o", c), instr_o, f_instr(q[0]));
      end
      v  = (c < 36) && (c % 3 != 2);
      rd = (c >= 36) || ((c % 4 != 1) && (c % 5 != 3));
      drive(1'b0, v, rd, 1'b0, 1'b0, next_pc);
      acc = v && (q.size() < 2);
      del = rd && (q.size() > 0);
      @(posedge clk);
      if (del) begin
        void'(q.pop_front());
        popped++;
      end
      if (acc) begin
        q.push_back(next_pc);
        next_pc += 32'd4;
        pushed++;
      end
    end
    @(negedge clk);
    chk("stream drained", {31'd0, valid_o}, 32'd0);
    chk("stream count", popped, pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
